// File: rtl/mux_rr_arb.sv
// Registered N-channel valid/ready multiplexer.
// Arbitration is either an explicit channel select or round-robin among the valid channels.
module mux_rr_arb #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rr_en,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] hi_mask;

  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_chan_reg;

  logic             accept;
  logic             xfer;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  // hi_mask holds the valid channels at or above the pointer; they win over wrapped ones
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign hi_mask[gi]  = in_valid[gi] && (SEL_W'(gi) >= ptr_reg);
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign accept = !out_valid_reg || out_ready;
  assign xfer   = grant_valid && accept && !rst;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    if (rr_en) begin
      // Downward scans leave the lowest index; the upper segment overrides the wrapped one.
      for (int i = CHANNELS-1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
          grant_data  = ch_data[i];
        end
      end
      for (int i = CHANNELS-1; i >= 0; i--) begin
        if (hi_mask[i]) begin
          grant_idx  = SEL_W'(i);
          grant_data = ch_data[i];
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
          grant_data  = ch_data[i];
        end
      end
    end
  end

  assign ptr_next = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= grant_data;
      out_chan_reg  <= grant_idx;
      if (rr_en) begin
        ptr_reg <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Randomized and directed bench for mux_rr_arb: a 64x4 instance and an 8x3 instance,
// both checked every cycle against a queue-free behavioural model of the arbitration rules.
module tb_mux_rr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic         a_rr_en = 1'b0;
  logic [1:0]   a_sel = '0;
  logic [3:0]   a_in_valid = '0;
  logic [3:0]   a_in_ready;
  logic [255:0] a_in_data = '0;
  logic         a_out_valid;
  logic         a_out_ready = 1'b1;
  logic [63:0]  a_out_data;
  logic [1:0]   a_out_chan;

  // Instance B: WIDTH=8, CHANNELS=3
  logic         b_rr_en = 1'b0;
  logic [1:0]   b_sel = '0;
  logic [2:0]   b_in_valid = '0;
  logic [2:0]   b_in_ready;
  logic [23:0]  b_in_data = '0;
  logic         b_out_valid;
  logic         b_out_ready = 1'b1;
  logic [7:0]   b_out_data;
  logic [1:0]   b_out_chan;

  mux_rr_arb #(.WIDTH(64), .CHANNELS(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .rr_en(a_rr_en), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_chan(a_out_chan)
  );

  mux_rr_arb #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .rr_en(b_rr_en), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_chan(b_out_chan)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Grant rule: -1 when nothing may transfer this cycle.
  function automatic int exp_grant(input int ch, input bit rr, input int s,
                                   input logic [15:0] v, input int ptr,
                                   input bit acc, input bit r);
    if (r || !acc) return -1;
    if (!rr) return (s < ch && v[s] === 1'b1) ? s : -1;
    for (int k = 0; k < ch; k++) begin
      int c;
      c = (ptr + k) % ch;
      if (v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  // Model of the output register and rotation pointer, index 0 = A, 1 = B.
  bit          m_ov  [2];
  logic [63:0] m_od  [2];
  int          m_oc  [2];
  int          m_ptr [2];

  always @(posedge clk) begin
    int ga, gb;
    ga = exp_grant(4, a_rr_en, int'(a_sel), 16'(a_in_valid), m_ptr[0], !m_ov[0] || a_out_ready, rst);
    gb = exp_grant(3, b_rr_en, int'(b_sel), 16'(b_in_valid), m_ptr[1], !m_ov[1] || b_out_ready, rst);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ov[i] = 1'b0; m_od[i] = '0; m_oc[i] = 0; m_ptr[i] = 0;
      end
    end else begin
      if (ga >= 0) begin
        m_ov[0] = 1'b1; m_od[0] = a_in_data[ga*64 +: 64]; m_oc[0] = ga;
        if (a_rr_en) m_ptr[0] = (ga == 3) ? 0 : ga + 1;
      end else if (a_out_ready) begin
        m_ov[0] = 1'b0;
      end
      if (gb >= 0) begin
        m_ov[1] = 1'b1; m_od[1] = 64'(b_in_data[gb*8 +: 8]); m_oc[1] = gb;
        if (b_rr_en) m_ptr[1] = (gb == 2) ? 0 : gb + 1;
      end else if (b_out_ready) begin
        m_ov[1] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int ga, gb;
    if (chk_en) begin
      ga = exp_grant(4, a_rr_en, int'(a_sel), 16'(a_in_valid), m_ptr[0], !m_ov[0] || a_out_ready, rst);
      gb = exp_grant(3, b_rr_en, int'(b_sel), 16'(b_in_valid), m_ptr[1], !m_ov[1] || b_out_ready, rst);
      chk("a_in_ready", 64'(a_in_ready), (ga >= 0) ? (64'd1 << ga) : 64'd0);
      chk("a_out_valid", 64'(a_out_valid), 64'(m_ov[0]));
      chk("a_out_data", a_out_data, m_od[0]);
      chk("a_out_chan", 64'(a_out_chan), 64'(m_oc[0]));
      chk("b_in_ready", 64'(b_in_ready), (gb >= 0) ? (64'd1 << gb) : 64'd0);
      chk("b_out_valid", 64'(b_out_valid), 64'(m_ov[1]));
      chk("b_out_data", 64'(b_out_data), m_od[1]);
      chk("b_out_chan", 64'(b_out_chan), 64'(m_oc[1]));
      if (ga >= 0) $display("A xfer ch=%0d data=%h rr=%0d", ga, a_in_data[ga*64 +: 64], a_rr_en);
      if (gb >= 0) $display("B xfer ch=%0d data=%h rr=%0d", gb, b_in_data[gb*8 +: 8], b_rr_en);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] words [4];

  initial begin
    words[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    words[1] = 64'h5555_5555_5555_5555;
    words[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    words[3] = 64'h3333_3333_3333_3333;
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Explicit select, all channels valid
    a_rr_en = 1'b0;
    a_in_valid = 4'hF;
    for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = words[i];
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      @(negedge clk);
      chk("expl_ready", 64'(a_in_ready), 64'd1 << s);
      if (s > 0) begin
        chk("expl_data", a_out_data, words[s-1]);
        chk("expl_chan", 64'(a_out_chan), 64'(s-1));
      end
      cyc();
    end

    // Round-robin rotation with all valid
    a_rr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("expl_data_last", a_out_data, words[3]);
      if (k > 0) begin
        chk("rr_chan", 64'(a_out_chan), 64'((k-1) % 4));
        chk("rr_valid", 64'(a_out_valid), 64'd1);
      end
      cyc();
    end

    // Sparse round-robin: only ch1 and ch3
    a_in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sparse_ready", 64'(a_in_ready), (k % 2 == 0) ? 64'd2 : 64'd8);
      if (k > 0) chk("sparse_chan", 64'(a_out_chan), ((k-1) % 2 == 0) ? 64'd1 : 64'd3);
      cyc();
    end

    // Reset mid-stream (out_valid=1, pointer at 2)
    rst = 1'b1;
    a_in_valid = 4'hF;
    @(negedge clk);
    chk("rst_ready", 64'(a_in_ready), 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data", a_out_data, 64'd0);
    chk("rst_chan", 64'(a_out_chan), 64'd0);
    chk("rst_first_grant", 64'(a_in_ready), 64'd1);
    cyc();

    // Backpressure: load F0F0 then stall for 5 cycles
    a_rr_en = 1'b0;
    a_sel = 2'd0;
    a_in_data[63:0] = 64'hF0F0_F0F0_F0F0_F0F0;
    @(negedge clk);
    chk("bp_pre_chan", 64'(a_out_chan), 64'd0);
    cyc();
    a_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_sel = 2'(k % 4);
      for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_data", a_out_data, 64'hF0F0_F0F0_F0F0_F0F0);
      chk("bp_ready", 64'(a_in_ready), 64'd0);
      cyc();
    end
    a_rr_en = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(a_in_ready), 64'd2);
    cyc();
    @(negedge clk);
    chk("bp_release_chan", 64'(a_out_chan), 64'd1);
    cyc();
    a_in_valid = '0;

    // Three-channel instance: rotation 0,1,2,0 then out-of-range select
    b_rr_en = 1'b1;
    b_in_valid = 3'b111;
    b_in_data = 24'h33_22_11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk("b_rot_chan", 64'(b_out_chan), 64'((k-1) % 3));
      cyc();
    end
    b_rr_en = 1'b0;
    b_sel = 2'd3;
    @(negedge clk);
    chk("b_rot_wrap_chan", 64'(b_out_chan), 64'd0);
    chk("b_sel3_ready", 64'(b_in_ready), 64'd0);
    chk("b_sel3_pending", 64'(b_out_valid), 64'd1);
    cyc();
    @(negedge clk);
    chk("b_sel3_drained", 64'(b_out_valid), 64'd0);
    cyc();

    // Randomized traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      a_rr_en     = $urandom_range(0, 1) == 1;
      a_sel       = 2'($urandom_range(0, 3));
      a_in_valid  = 4'($urandom);
      a_out_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = {$urandom, $urandom};
      b_rr_en     = $urandom_range(0, 1) == 1;
      b_sel       = 2'($urandom_range(0, 3));
      b_in_valid  = 3'($urandom);
      b_out_ready = $urandom_range(0, 3) != 0;
      b_in_data   = 24'($urandom);
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
